param_streamlined_divider: RTL and testbench
============================================

Name: param_streamlined_divider

Overview:
Multi-cycle restoring shift-subtract divider, generalised to a parameterised operand width W with run-time signed/unsigned mode.
- Produces a truncating (toward zero) quotient and a correctly signed remainder.
- Start/busy/done handshake with registered, held results.
- Serves datapath blocks that need occasional division without a combinational array.

Parameters:
W, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(W+1), iteration counter width (derived; not to be overridden)

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  reset, asynchronous, active-low
Start_Sig  input  1  request pulse; sampled only while Busy=0
Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
Dividend  input  W  dividend; latched on accepted start
Divisor  input  W  divisor; latched on accepted start
Busy  output  1  high from the cycle after an accepted start until Done_Sig cycle inclusive
Done_Sig  output  1  one-cycle pulse: results valid
Quotient  output  W  registered quotient, held until next Done_Sig
Remainder  output  W  registered remainder, held until next Done_Sig
Div_Zero  output  1  present only with DIVIDER_ZERO_CHECK_EN; see Optional Feature

Behaviour:
- Reset (async, RSTn=0): state IDLE; counter, internal registers, Busy, Done_Sig, Quotient, Remainder, Div_Zero all 0. Reset mid-operation aborts with no Done_Sig; Start_Sig is ignored until the first clock edge after RSTn deasserts.
- States:
  - IDLE: when Start_Sig=1, latch operands and mode, then go to LOAD.
  - LOAD (1 cycle):
    - Form magnitudes: negate an operand only if Signed_Mode=1 and its MSB=1.
    - Record quotient sign = dividend MSB XOR divisor MSB, and remainder sign = dividend MSB (both gated by Signed_Mode).
    - Clear the partial remainder (W+1 bits); counter = W.
  - ITER (W cycles): each cycle:
    - Shift {partial remainder, dividend magnitude} left by 1.
    - Trial-subtract the divisor magnitude (W+1-bit). If the result is non-negative, keep it and set quotient LSB=1; else restore and set quotient LSB=0.
    - Decrement counter; leave ITER when counter reaches 1.
  - FIX (1 cycle): conditionally negate quotient and remainder per the recorded signs; register into Quotient/Remainder; go to DONE.
  - DONE (1 cycle): Done_Sig=1, Busy=1; next state IDLE.
- Latency: accepted start at edge N → Done_Sig high in cycle N+W+3. Throughput: one division per W+4 cycles.
- Start_Sig while Busy=1 (including the DONE cycle) is ignored; operand changes after acceptance have no effect.
- Overflow: signed most-negative / -1 → Quotient = most-negative (wraps, 0x80 for W=8), Remainder = 0, no flag.
- Divisor 0 without the feature: the algorithm runs unmodified. Unsigned: Quotient = all ones, Remainder = dividend. Signed: all-ones magnitude with the sign rules applied, Remainder = dividend.
- Results satisfy Dividend = Quotient*Divisor + Remainder (mod 2^W); |Remainder| < |Divisor|.

Optional Feature:
Macro DIVIDER_ZERO_CHECK_EN.
- Defined:
  - Div_Zero port exists.
  - In LOAD, a divisor of 0 skips ITER and FIX: next state DONE, so Done_Sig arrives in cycle N+2.
  - Quotient = all ones, Remainder = latched Dividend unmodified, Div_Zero = 1.
  - Div_Zero is held with the results and cleared at the next Done_Sig for a non-zero divisor.
- Undefined: no Div_Zero port; divisor 0 follows the normal W+3 path, with results as stated in Behaviour.

Decomposition:
- Package divider_pkg:
  - State enum (IDLE, LOAD, ITER, FIX, DONE).
  - Function for conditional two's-complement negate.
- Sub-module divider_sign_fix: combinational conditional-negate of W bits (enable, in → out), instantiated for the operand magnitudes and the result correction.

Test Plan (W=8):
- Unsigned 100/7 → Quotient=14 (0x0E), Remainder=2; Done_Sig exactly 11 cycles after the start edge, 1 cycle wide.
- Signed -100/7 (0x9C/0x07) → Quotient=0xF2 (-14), Remainder=0xFE (-2); signed 7/-100 → Quotient=0, Remainder=7.
- Signed -128/-1 (0x80/0xFF) → Quotient=0x80, Remainder=0; unsigned 0x80/0xFF → Quotient=0, Remainder=0x80.
- Divisor 0, dividend 0x2A:
  - With DIVIDER_ZERO_CHECK_EN: Done_Sig after 2 cycles, Quotient=0xFF, Remainder=0x2A, Div_Zero=1.
  - Without the macro: Done_Sig after 11 cycles, Quotient=0xFF, Remainder=0x2A.
- Start_Sig held high with operands changing every cycle → only the operands of the first IDLE sample are used; the next division starts W+4 cycles later.
- RSTn pulsed low mid-ITER → all outputs 0 immediately, no Done_Sig; the next start completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the shift-subtract divider.
// DIVIDER_ZERO_CHECK_EN in the top enables the divide-by-zero shortcut.
package divider_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_e;

    function automatic logic [MAX_W-1:0] cond_neg(
        input logic             en,
        input logic [MAX_W-1:0] x
    );
        return en ? (MAX_W'(0) - x) : x;
    endfunction

endpackage

// File: rtl/divider_sign_fix.sv
// Conditional two's-complement negate of a W-bit value.
// Used for operand magnitudes and for final result sign correction.
module divider_sign_fix
    import divider_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         en_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    assign out_o = W'(cond_neg(en_i, MAX_W'(in_i)));

endmodule

// File: rtl/param_streamlined_divider.sv
// Multi-cycle restoring divider, parameterised width, signed/unsigned.
// Optional macro DIVIDER_ZERO_CHECK_EN adds Div_Zero and a fast x/0 path.
module param_streamlined_divider
    import divider_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W+1)
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         Start_Sig,
    input  logic         Signed_Mode,
    input  logic [W-1:0] Dividend,
    input  logic [W-1:0] Divisor,
    output logic         Busy,
    output logic         Done_Sig,
`ifdef DIVIDER_ZERO_CHECK_EN
    output logic         Div_Zero,
`endif
    output logic [W-1:0] Quotient,
    output logic [W-1:0] Remainder
);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic             mode_q, mode_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W:0]       r_q, r_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rem_q, rem_d;
`ifdef DIVIDER_ZERO_CHECK_EN
    logic             dz_q, dz_d;
`endif

    logic [W-1:0] dvd_mag;
    logic [W-1:0] dvs_mag;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;
    logic [W+1:0] shifted;
    logic [W+1:0] diff;
    logic         fits;

    divider_sign_fix #(.W(W)) u_dvd_mag (
        .en_i  (mode_q & dvd_q[W-1]),
        .in_i  (dvd_q),
        .out_o (dvd_mag)
    );

    divider_sign_fix #(.W(W)) u_dvs_mag (
        .en_i  (mode_q & dvs_q[W-1]),
        .in_i  (dvs_q),
        .out_o (dvs_mag)
    );

    divider_sign_fix #(.W(W)) u_quo_fix (
        .en_i  (qneg_q),
        .in_i  (a_q),
        .out_o (quo_fix)
    );

    divider_sign_fix #(.W(W)) u_rem_fix (
        .en_i  (rneg_q),
        .in_i  (r_q[W-1:0]),
        .out_o (rem_fix)
    );

    // Extra headroom bit makes the trial-subtract sign unambiguous.
    assign shifted = {r_q, a_q[W-1]};
    assign diff    = shifted - {2'b00, b_q};
    assign fits    = ~diff[W+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start_Sig) begin
                    dvd_d   = Dividend;
                    dvs_d   = Divisor;
                    mode_d  = Signed_Mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d     = dvd_mag;
                b_d     = dvs_mag;
                r_d     = '0;
                qneg_d  = mode_q & (dvd_q[W-1] ^ dvs_q[W-1]);
                rneg_d  = mode_q & dvd_q[W-1];
                cnt_d   = CNT_W'(W);
                state_d = ITER;
`ifdef DIVIDER_ZERO_CHECK_EN
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            ITER: begin
                a_d   = {a_q[W-2:0], fits};
                r_d   = fits ? diff[W:0] : shifted[W:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = quo_fix;
                rem_d   = rem_fix;
`ifdef DIVIDER_ZERO_CHECK_EN
                dz_d    = 1'b0;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIVIDER_ZERO_CHECK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done_Sig  = (state_q == DONE);
    assign Quotient  = quo_q;
    assign Remainder = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    assign Div_Zero  = dz_q;
`endif

endmodule

// File: tb/tb_param_streamlined_divider.sv
// Directed bench for param_streamlined_divider at W=8.
// Honours DIVIDER_ZERO_CHECK_EN for the divide-by-zero cases.
module tb_param_streamlined_divider;

    localparam int W = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = W + 3;
`endif

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         Start_Sig = 1'b0;
    logic         Signed_Mode = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic         Busy;
    logic         Done_Sig;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
`ifdef DIVIDER_ZERO_CHECK_EN
    logic         Div_Zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    param_streamlined_divider #(.W(W)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Start_Sig   (Start_Sig),
        .Signed_Mode (Signed_Mode),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Busy        (Busy),
        .Done_Sig    (Done_Sig),
`ifdef DIVIDER_ZERO_CHECK_EN
        .Div_Zero    (Div_Zero),
`endif
        .Quotient    (Quotient),
        .Remainder   (Remainder)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency is counted with the accepting edge as cycle 1.
    task automatic run_div(
        input string        tag,
        input logic         mode,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] eq,
        input logic [W-1:0] er,
        input int           elat
    );
        int   lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge CLK);
        Signed_Mode = mode;
        Dividend    = a;
        Divisor     = b;
        Start_Sig   = 1'b1;
        while (!seen && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
            if (lat == 1) begin
                Start_Sig = 1'b0;
                Dividend  = ~a;
                Divisor   = ~b;
                check({tag, "_busy"}, 32'(Busy), 32'(1));
            end
            seen = Done_Sig;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(Quotient), 32'(eq));
        check({tag, "_r"}, 32'(Remainder), 32'(er));
`ifdef DIVIDER_ZERO_CHECK_EN
        check({tag, "_dz"}, 32'(Div_Zero), 32'(b == '0));
`endif
        @(posedge CLK);
        #1;
        check({tag, "_pulse"}, 32'(Done_Sig), 32'(0));
        check({tag, "_idle"}, 32'(Busy), 32'(0));
        check({tag, "_hold"}, 32'(Quotient), 32'(eq));
    endtask

    int           ndone;
    int           done_k [2];
    logic [W-1:0] done_q [2];
    logic [W-1:0] done_r [2];

    initial begin
        #1;
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done_Sig), 32'(0));
        check("rst_q", 32'(Quotient), 32'(0));
        check("rst_r", 32'(Remainder), 32'(0));
        #12;
        @(negedge CLK);
        RSTn = 1'b1;

        run_div("u100_7", 1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, W + 3);
        run_div("sm100_7", 1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, W + 3);
        run_div("s7_m100", 1'b1, 8'h07, 8'h9C, 8'h00, 8'h07, W + 3);
        run_div("s_ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, W + 3);
        run_div("u80_ff", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, W + 3);
        run_div("zero", 1'b0, 8'h2A, 8'h00, 8'hFF, 8'h2A, ZLAT);
        run_div("u200_9", 1'b0, 8'd200, 8'd9, 8'd22, 8'd2, W + 3);

        // Start held high, operands change every cycle.
        ndone = 0;
        @(negedge CLK);
        Signed_Mode = 1'b0;
        Start_Sig   = 1'b1;
        for (int k = 0; k < 24; k++) begin
            Dividend = 8'(50 + 3 * k);
            Divisor  = 8'(3 + (k % 5));
            @(posedge CLK);
            #1;
            if (Done_Sig && ndone < 2) begin
                done_k[ndone] = k;
                done_q[ndone] = Quotient;
                done_r[ndone] = Remainder;
            end
            if (Done_Sig) ndone++;
        end
        Start_Sig = 1'b0;
        @(posedge CLK);
        #1;
        check("tp_ndone", 32'(ndone), 32'(2));
        check("tp_k0", 32'(done_k[0]), 32'(W + 2));
        check("tp_q0", 32'(done_q[0]), 32'(16));
        check("tp_r0", 32'(done_r[0]), 32'(2));
        check("tp_k1", 32'(done_k[1]), 32'(2 * W + 6));
        check("tp_q1", 32'(done_q[1]), 32'(17));
        check("tp_r1", 32'(done_r[1]), 32'(1));
        check("tp_idle", 32'(Busy), 32'(0));

        // Reset in the middle of the iterations.
        @(negedge CLK);
        Dividend  = 8'd100;
        Divisor   = 8'd7;
        Start_Sig = 1'b1;
        @(posedge CLK);
        #1;
        Start_Sig = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("mrst_busy", 32'(Busy), 32'(0));
        check("mrst_done", 32'(Done_Sig), 32'(0));
        check("mrst_q", 32'(Quotient), 32'(0));
        check("mrst_r", 32'(Remainder), 32'(0));
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            if (Done_Sig) ndone++;
            if (k == 2) RSTn = 1'b1;
        end
        check("mrst_nodone", 32'(ndone), 32'(0));
        run_div("post_rst", 1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, W + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
